// File: rtl/prio_encoder_seq_if.sv
// rtl/prio_encoder_seq_if.sv - request load / code emission handshake bundle
interface prio_encoder_seq_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         load_i;
    logic [N-1:0] req_i;
    logic         ready_i;
    logic         valid_o;
    logic [W-1:0] code_o;

    modport master (
        output load_i,
        output req_i,
        output ready_i,
        input  valid_o,
        input  code_o
    );

    modport slave (
        input  load_i,
        input  req_i,
        input  ready_i,
        output valid_o,
        output code_o
    );
endinterface

// File: rtl/prio_encoder_seq.sv
// rtl/prio_encoder_seq.sv - pending-request register drained lowest-index-first as a code stream
module prio_encoder_seq #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    prio_encoder_seq_if.slave   bus,
    output logic [N-1:0]        pending_o,
    output logic                ovf_o
);
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic [N-1:0] popmask;
    logic [N-1:0] load_mask;
    logic         ovf_q;
    logic         ovf_d;
    logic         valid;
    logic         pop;
    logic [W-1:0] code;

    // Downward scan so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        code = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                code = W'(k);
            end
        end
    end

    assign valid     = |pending_q;
    assign pop       = valid & bus.ready_i;
    assign popmask   = pop ? (N'(1) << code) : '0;
    assign load_mask = bus.load_i ? bus.req_i : '0;

    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (clr_i) begin
            pending_d = '0;
            ovf_d     = 1'b0;
        end else begin
            // A bit popped this edge and reloaded counts as a fresh request, not a duplicate.
            pending_d = (pending_q & ~popmask) | load_mask;
            if ((load_mask & pending_q & ~popmask) != '0) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.valid_o = valid;
    assign bus.code_o  = code;
    assign pending_o   = pending_q;
    assign ovf_o       = ovf_q;
endmodule

// File: doc/prio_encoder_seq.md
Name: prio_encoder_seq

Overview:
- Sequential counterpart of the team's 3-to-8 decoder: accepts request bit vectors and emits their binary indices one at a time over a valid/ready handshake.
- Holds a pending-request register and drains it lowest-index-first.
- Sits between request/flag sources (interrupt lines, decoder-style one-hot selects) and any consumer that needs a packed code stream.

Parameters:
- N, 8, number of request lines; must equal 2**W.
- W, 3, code width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr_i  input  1  synchronous clear of pending register and overflow flag.
- load_i  input  1  when 1, req_i is OR-ed into the pending register this edge.
- req_i  input  N  request vector; bit k means "emit code k".
- ready_i  input  1  consumer accepts code_o this cycle.
- valid_o  output  1  code_o holds a pending index.
- code_o  output  W  index of the lowest set pending bit; 0 when valid_o=0.
- pending_o  output  N  current pending register, for debug/status.
- ovf_o  output  1  sticky: a request was loaded while its bit was already pending.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, mid-drain included): pending=0, ovf=0. Therefore valid_o=0, code_o=0, pending_o=0, ovf_o=0. Holds until rst_n rises; the first update is on the next rising clk edge.
- valid_o = OR of pending. Combinational from the register only; no input-to-output combinational path.
- code_o = index of the lowest set pending bit (bit 0 highest priority). 0 when pending=0.
- Pop: pop = valid_o & ready_i. On pop, pending[code_o] clears at the edge.
- Next-state, evaluated in this order:
  - clr_i=1: pending := 0, ovf := 0. Load and pop are ignored.
  - otherwise: pending := (pending & ~popmask) | (load_i ? req_i : 0), where popmask = pop ? onehot(code_o) : 0.
- Simultaneous pop and load of the same bit: the bit stays set (new request). No overflow.
- Overflow:
  - Condition: load_i & clr_i=0 & (req_i & pending & ~popmask) != 0.
  - Effect: ovf := 1. The duplicate request merges and is not queued twice.
  - ovf stays set until clr_i or reset.
- Latency:
  - load at edge t gives valid_o=1 during cycle t+1.
  - Back-to-back pops with ready_i=1 drain one code per cycle.
  - Emission order is ascending index among bits pending at each cycle.
- Loading a bit lower than the currently presented code preempts it next cycle. code_o is only guaranteed stable while valid_o=1 and no load occurs.
- ready_i while valid_o=0: no effect.
- req_i with load_i=0: ignored.
- load_i with req_i=0: no effect.
- All-ones load: drains codes 0..N-1 in N cycles, then valid_o=0.
- Width rules: code_o is exactly W bits. The priority scan covers all N bits; no wrap-around. The implementation may use a loop or a tree of the team's 2-input gates; behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with pending=8'hA5 -> immediately valid_o=0, code_o=0, pending_o=0, ovf_o=0; after release, no codes emitted until a load.
- Basic drain: load req=8'b1001_0010 with ready_i=1 held -> code_o sequence 1,4,7 on consecutive cycles starting one cycle after load; valid_o falls after code 7; ovf_o=0.
- Backpressure: load 8'h81, ready_i=0 for 3 cycles -> code_o=0 stable, valid_o=1; then ready_i=1 -> codes 0,7, then idle.
- Preemption and merge:
  - Setup: pending 8'h80, present code 7 with ready_i=0.
  - Load 8'h04 -> next cycle code_o=2; drain order 2,7.
  - Load 8'h80 again while 7 is pending (not popping) -> ovf_o=1 sticky; bit 7 emitted only once.
- Same-bit pop+load: pending 8'h01, ready_i=1 and load 8'h01 in the same cycle -> bit 0 still pending, code_o=0 next cycle, ovf_o=0.
- Clear: pending 8'hFF with ovf_o=1; clr_i=1 together with load 8'h0F -> next cycle pending_o=0, valid_o=0, ovf_o=0 (clear dominates load).
